// File: rtl/apb_pkg.sv
// Shared types for the arbitrated APB master: FSM state encoding and the latched request record.
// Pure declarations; no timing or flow control of its own.
package apb_pkg;

    localparam int DEFAULT_TIMEOUT = 15;
    localparam int APB_ADDR_W      = 32;
    localparam int APB_DATA_W      = 32;

    typedef enum logic [1:0] {
        APB_IDLE,
        APB_SETUP,
        APB_ACCESS
    } apb_state_e;

    typedef struct packed {
        logic                  write;
        logic [APB_ADDR_W-1:0] addr;
        logic [APB_DATA_W-1:0] wdata;
    } apb_req_t;

endpackage

// File: rtl/apb_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, priority starts after the last accepted winner.
// Zero latency; the pointer only moves when i_advance accepts the current grant.
module apb_rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [NUM_REQ-1:0] i_req,
    input  logic               i_advance,
    output logic [NUM_REQ-1:0] o_grant
);

    localparam int IW = $clog2(NUM_REQ);

    logic [IW-1:0] r_last;
    logic [IW-1:0] w_win;
    logic [IW-1:0] w_idx;
    logic [IW:0]   w_sum;
    logic          w_found;

    // Scan from r_last+1 upward, wrapping at NUM_REQ; the first request seen wins.
    always_comb begin
        o_grant = '0;
        w_win   = r_last;
        w_found = 1'b0;
        w_sum   = '0;
        w_idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_sum = {1'b0, r_last} + (IW+1)'(k);
            if (w_sum >= (IW+1)'(NUM_REQ)) begin
                w_sum = w_sum - (IW+1)'(NUM_REQ);
            end
            w_idx = w_sum[IW-1:0];
            if (!w_found && i_req[w_idx]) begin
                o_grant[w_idx] = 1'b1;
                w_win          = w_idx;
                w_found        = 1'b1;
            end
        end
    end

    // Reset to the top index so requester 0 is first in line.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_last <= IW'(NUM_REQ - 1);
        end else if (i_advance && w_found) begin
            r_last <= w_win;
        end
    end

endmodule

// File: rtl/apb_rr_master.sv
// Arbitrated APB master: NUM_REQ requesters share one completer; accept->SETUP->ACCESS, rsp 3 cycles after accept with no waits.
// Requesters hold req_valid until req_ready; completer stalls via pready, aborted with error after TIMEOUT ACCESS cycles.
module apb_rr_master import apb_pkg::*; #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = APB_ADDR_W,
    parameter int DATA_W  = APB_DATA_W,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                      pclk,
    input  logic                      presetn,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_err,
    output logic                      psel,
    output logic                      penable,
    output logic                      pwrite,
    output logic [ADDR_W-1:0]         paddr,
    output logic [DATA_W-1:0]         pwdata,
    input  logic [DATA_W-1:0]         prdata,
    input  logic                      pready,
    input  logic                      pslverr
);

    localparam int              CW        = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]   LAST_WAIT = CW'(TIMEOUT - 1);

    apb_state_e          r_state;
    apb_state_e          w_state_nxt;
    apb_req_t            w_sel;
    apb_req_t            r_req;
    logic [NUM_REQ-1:0]  w_grant;
    logic [NUM_REQ-1:0]  r_owner;
    logic [NUM_REQ-1:0]  r_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_rdata;
    logic                r_rsp_err;
    logic [CW-1:0]       r_wait_cnt;
    logic                w_accept;
    logic                w_done;
    logic                w_abort;

    apb_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .i_clk     (pclk),
        .i_rst_n   (presetn),
        .i_req     (req_valid),
        .i_advance (w_accept),
        .o_grant   (w_grant)
    );

    // Write data is zeroed for reads at capture so pwdata never leaks stale data.
    always_comb begin
        w_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_sel.write = req_write[i];
                w_sel.addr  = APB_ADDR_W'(req_addr[i*ADDR_W +: ADDR_W]);
                w_sel.wdata = req_write[i] ? APB_DATA_W'(req_wdata[i*DATA_W +: DATA_W]) : '0;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_done      = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            APB_IDLE: begin
                if (|req_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = APB_SETUP;
                end
            end
            APB_SETUP: w_state_nxt = APB_ACCESS;
            APB_ACCESS: begin
                if (pready) begin
                    w_done      = 1'b1;
                    w_state_nxt = APB_IDLE;
                end else if (r_wait_cnt == LAST_WAIT) begin
                    w_abort     = 1'b1;
                    w_state_nxt = APB_IDLE;
                end
            end
            default: w_state_nxt = APB_IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_state <= APB_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_req       <= '0;
            r_owner     <= '0;
            r_wait_cnt  <= '0;
            r_rsp_valid <= '0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_req   <= w_sel;
                r_owner <= w_grant;
            end
            if (r_state == APB_SETUP) begin
                r_wait_cnt <= '0;
            end else if (r_state == APB_ACCESS && !pready) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end
            r_rsp_valid <= '0;
            if (w_done) begin
                r_rsp_valid <= r_owner;
                r_rsp_rdata <= r_req.write ? '0 : prdata;
                r_rsp_err   <= pslverr;
            end else if (w_abort) begin
                r_rsp_valid <= r_owner;
                r_rsp_rdata <= '0;
                r_rsp_err   <= 1'b1;
            end
        end
    end

    // Gated by presetn so nothing is offered to requesters while held in reset.
    assign req_ready = presetn ? (w_grant & {NUM_REQ{w_accept}}) : '0;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign psel      = (r_state != APB_IDLE);
    assign penable   = (r_state == APB_ACCESS);
    assign pwrite    = r_req.write;
    assign paddr     = ADDR_W'(r_req.addr);
    assign pwdata    = DATA_W'(r_req.wdata);

endmodule

// File: tb/tb_apb_rr_master.sv
// Directed bench for apb_rr_master: vector table of single transfers plus reset and contention sequences.
module tb_apb_rr_master;

    localparam int NR = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 15;

    logic             pclk = 1'b0;
    logic             presetn;
    logic [NR-1:0]    req_valid, req_write, req_ready, rsp_valid;
    logic [NR*AW-1:0] req_addr;
    logic [NR*DW-1:0] req_wdata;
    logic [DW-1:0]    rsp_rdata, pwdata, prdata;
    logic             rsp_err, psel, penable, pwrite, pready, pslverr;
    logic [AW-1:0]    paddr;

    int n_cmp = 0;
    int n_bad = 0;

    apb_rr_master #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .pclk      (pclk),
        .presetn   (presetn),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .prdata    (prdata),
        .pready    (pready),
        .pslverr   (pslverr)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        int          id;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          nwait;
        logic        slverr;
        logic [31:0] prdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          lat;
    } vec_t;

    vec_t          tbl [6];
    logic [NR-1:0] exp_g [4];
    int            cur;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s (step %0d): got 0x%0h, expected 0x%0h", name, cur, act, exp);
        end
    endtask

    // Completer raises pready on ACCESS cycle nwait+1 (cycle c counts from accept).
    task automatic run_vec(input vec_t v);
        logic [NR-1:0] oh;
        logic [31:0]   exp_pw;
        oh         = '0;
        oh[v.id]   = 1'b1;
        exp_pw     = v.wr ? v.wdata : 32'h0;
        @(posedge pclk); #1;
        req_valid[v.id]              = 1'b1;
        req_write[v.id]              = v.wr;
        req_addr[v.id*AW +: AW]      = v.addr;
        req_wdata[v.id*DW +: DW]     = v.wdata;
        prdata                       = v.prdata;
        pready                       = 1'b0;
        pslverr                      = 1'b0;
        @(negedge pclk);
        chk("accept_ready", req_ready, oh);
        chk("accept_psel", psel, 0);
        for (int c = 1; c <= v.lat; c++) begin
            @(posedge pclk); #1;
            if (c == 1) req_valid[v.id] = 1'b0;
            pready  = (c == v.nwait + 2);
            pslverr = pready & v.slverr;
            @(negedge pclk);
            if (c < v.lat) begin
                chk("psel", psel, 1);
                chk("penable", penable, (c >= 2));
                chk("rsp_early", rsp_valid, 0);
            end else begin
                chk("psel_end", psel, 0);
                chk("penable_end", penable, 0);
                chk("rsp_valid", rsp_valid, oh);
                chk("rsp_rdata", rsp_rdata, v.exp_rdata);
                chk("rsp_err", rsp_err, v.exp_err);
            end
            chk("paddr", paddr, v.addr);
            chk("pwdata", pwdata, exp_pw);
            chk("pwrite", pwrite, v.wr);
        end
        pready  = 1'b0;
        pslverr = 1'b0;
    endtask

    initial begin
        int ng;
        int last_acc;

        tbl[0] = '{id:0, wr:1'b1, addr:32'h0000_0010, wdata:32'hDEAD_BEEF, nwait:0,  slverr:1'b0,
                   prdata:32'hAAAA_AAAA, exp_rdata:32'h0,         exp_err:1'b0, lat:3};
        tbl[1] = '{id:1, wr:1'b0, addr:32'h0000_0020, wdata:32'hFFFF_FFFF, nwait:3,  slverr:1'b0,
                   prdata:32'h1234_5678, exp_rdata:32'h1234_5678, exp_err:1'b0, lat:6};
        tbl[2] = '{id:1, wr:1'b1, addr:32'h0000_0004, wdata:32'h0BAD_F00D, nwait:0,  slverr:1'b1,
                   prdata:32'h0,         exp_rdata:32'h0,         exp_err:1'b1, lat:3};
        tbl[3] = '{id:0, wr:1'b0, addr:32'h0000_0030, wdata:32'h0,         nwait:0,  slverr:1'b0,
                   prdata:32'hCAFE_F00D, exp_rdata:32'hCAFE_F00D, exp_err:1'b0, lat:3};
        tbl[4] = '{id:1, wr:1'b0, addr:32'h0000_0040, wdata:32'h0,         nwait:99, slverr:1'b0,
                   prdata:32'h5555_5555, exp_rdata:32'h0,         exp_err:1'b1, lat:17};
        tbl[5] = '{id:0, wr:1'b0, addr:32'h0000_0044, wdata:32'h0,         nwait:14, slverr:1'b0,
                   prdata:32'h0F0F_0F0F, exp_rdata:32'h0F0F_0F0F, exp_err:1'b0, lat:17};
        exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;

        // Reset state with live requests and a ready completer.
        cur       = -1;
        presetn   = 1'b0;
        req_valid = 2'b11;
        req_write = 2'b11;
        req_addr  = {32'h0000_1111, 32'h0000_2222};
        req_wdata = {32'h3333_3333, 32'h4444_4444};
        prdata    = 32'h7777_7777;
        pready    = 1'b1;
        pslverr   = 1'b1;
        #1;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_psel", psel, 0);
        chk("rst_penable", penable, 0);
        chk("rst_pwrite", pwrite, 0);
        chk("rst_paddr", paddr, 0);
        chk("rst_pwdata", pwdata, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_rsp_err", rsp_err, 0);
        repeat (2) @(posedge pclk);
        #1;
        req_valid = '0;
        pready    = 1'b0;
        pslverr   = 1'b0;
        presetn   = 1'b1;

        for (int i = 0; i < 6; i++) begin
            cur = i;
            run_vec(tbl[i]);
        end

        // Reset asserted during the second wait cycle of a req0 read.
        cur = 6;
        @(posedge pclk); #1;
        req_valid[0]       = 1'b1;
        req_write[0]       = 1'b0;
        req_addr[0 +: AW]  = 32'h0000_0050;
        pready             = 1'b0;
        @(negedge pclk);
        chk("mr_accept", req_ready, 2'b01);
        @(posedge pclk); #1;
        req_valid = '0;
        @(negedge pclk);
        chk("mr_setup_psel", psel, 1);
        @(posedge pclk); #1;
        @(negedge pclk);
        chk("mr_access_penable", penable, 1);
        @(posedge pclk); #1;
        presetn   = 1'b0;
        req_valid = 2'b11;
        #1;
        chk("mr_psel", psel, 0);
        chk("mr_penable", penable, 0);
        chk("mr_pwrite", pwrite, 0);
        chk("mr_paddr", paddr, 0);
        chk("mr_pwdata", pwdata, 0);
        chk("mr_req_ready", req_ready, 0);
        chk("mr_rsp_valid", rsp_valid, 0);
        chk("mr_rsp_err", rsp_err, 0);
        repeat (3) begin
            @(negedge pclk);
            chk("mr_hold_rsp", rsp_valid, 0);
            chk("mr_hold_psel", psel, 0);
        end

        // Release with both requesters held valid: expect 0,1,0,1, accepts 3 cycles apart.
        cur = 7;
        @(posedge pclk); #1;
        presetn  = 1'b1;
        pready   = 1'b1;
        ng       = 0;
        last_acc = 0;
        for (int cyc = 0; cyc < 40 && ng < 4; cyc++) begin
            @(negedge pclk);
            if (req_ready != '0) begin
                chk("cont_grant", req_ready, exp_g[ng]);
                chk("cont_psel_idle", psel, 0);
                if (ng > 0) chk("cont_gap", cyc - last_acc, 3);
                last_acc = cyc;
                ng++;
            end
            @(posedge pclk); #1;
        end
        chk("cont_count", ng, 4);
        req_valid = '0;
        pready    = 1'b0;
        repeat (5) @(posedge pclk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
